// File: rtl/carry_event_timer_pkg.sv
// Shared types and defaults for the carry-driven interval timer.
package carry_event_timer_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/carry_event_timer_if.sv
// Control/status bundle between a controller and the carry event timer.
// start/stop are single-cycle command pulses with no back-pressure; status outputs are registered levels, done is a one-cycle pulse.
interface carry_event_timer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [CNT_W-1:0] target;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] events;
  logic             overrun;

  modport master (
    output start, stop, auto_reload, target,
    input  busy, done, events, overrun
  );

  modport slave (
    input  start, stop, auto_reload, target,
    output busy, done, events, overrun
  );
endinterface

// File: rtl/carry_event_timer_rise_detect.sv
// Rising-edge detector; the reset value of the history flop decides whether a level held across reset counts as an edge.
module carry_event_timer_rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic Reset,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) sig_q <= RST_VAL;
    else        sig_q <= sig_d;
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/carry_event_timer.sv
// Counts carry rising edges against a programmable target; start/stop FSM, one-cycle done, optional auto-reload, sticky overrun.
module carry_event_timer
  import carry_event_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                carry_in,
  carry_event_timer_if.slave  bus,
  output state_e              dbg_state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] events_q, events_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             ev;
  logic [CNT_W-1:0] events_inc;

  carry_event_timer_rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk    (clk),
    .Reset  (Reset),
    .sig_in (carry_in),
    .rise   (ev)
  );

  assign events_inc = events_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    events_d  = events_q;
    target_d  = target_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (bus.stop) begin
      state_d  = ST_IDLE;
      events_d = '0;
    end else if (bus.start) begin
      // Any edge coinciding with start belongs to the previous interval and is dropped.
      target_d  = bus.target;
      reload_d  = bus.auto_reload;
      events_d  = '0;
      overrun_d = 1'b0;
      if (bus.target == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE: events_d = '0;
        ST_RUN: begin
          // After a reload pulse events showed target for one cycle; clear it now.
          if (done_q) begin
            events_d = '0;
          end else if (ev) begin
            events_d = events_inc;
            if (events_inc == target_q) begin
              done_d = 1'b1;
              if (!reload_q) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (ev) overrun_d = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          events_d = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      events_q  <= '0;
      target_q  <= '0;
      reload_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      events_q  <= events_d;
      target_q  <= target_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.events  = events_q;
  assign bus.overrun = overrun_q;
  assign dbg_state   = state_q;

endmodule
